multicycle_ctrl_fsm: RTL

Parametrised multicycle MIPS control unit: a rising-edge state machine that sequences fetch, decode, execute, memory and write-back, and drives the datapath strobes each cycle. Unlike the previous control unit, it adds:
- memory wait-state handshakes,
- BNE,
- a sticky HALTED state,
- illegal-opcode detection,
- a saturating retired-instruction counter.

It sits between the instruction register opcode field and the multicycle datapath.

---
 rtl/multicycle_ctrl_pkg.sv | 80 ++++++++
 rtl/multicycle_ctrl_fsm_if.sv | 41 ++++
 rtl/sat_counter.sv | 19 +
 rtl/multicycle_ctrl_fsm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared opcode, ALU-code, state and mux-select definitions for the multicycle control unit.
package multicycle_ctrl_pkg;

  localparam int unsigned OPC_W = 6;
  localparam int unsigned ALU_W = 3;

  localparam logic [OPC_W-1:0] OP_ADDU  = 6'b000000;
  localparam logic [OPC_W-1:0] OP_SUBU  = 6'b000001;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPC_W-1:0] OP_OR    = 6'b010000;
  localparam logic [OPC_W-1:0] OP_AND   = 6'b010001;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPC_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPC_W-1:0] OP_SLTU  = 6'b100110;
  localparam logic [OPC_W-1:0] OP_SLTIU = 6'b100111;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b110101;
  localparam logic [OPC_W-1:0] OP_J     = 6'b111000;
  localparam logic [OPC_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OPC_W-1:0] OP_HALT  = 6'b111111;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLT = 3'b010,
    ALU_SLL = 3'b100,
    ALU_OR  = 3'b101,
    ALU_AND = 3'b110
  } alu_op_t;

  typedef enum logic [3:0] {
    ST_IF     = 4'd0,
    ST_ID     = 4'd1,
    ST_EXE_AL = 4'd2,
    ST_EXE_BR = 4'd3,
    ST_EXE_LS = 4'd4,
    ST_MEM    = 4'd5,
    ST_WB_AL  = 4'd6,
    ST_WB_LD  = 4'd7,
    ST_HALTED = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'b00,
    PCSRC_BRANCH = 2'b01,
    PCSRC_RS     = 2'b10,
    PCSRC_JUMP   = 2'b11
  } pcsrc_t;

  typedef enum logic [1:0] {
    REGDST_RA = 2'b00,
    REGDST_RT = 2'b01,
    REGDST_RD = 2'b10
  } regdst_t;

  // True for every opcode the control unit can sequence.
  function automatic logic op_known(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_ADDU, OP_SUBU, OP_ADDIU, OP_OR, OP_AND, OP_ORI, OP_SLL,
      OP_SLTU, OP_SLTIU, OP_SW, OP_LW, OP_BEQ, OP_BNE,
      OP_J, OP_JR, OP_JAL, OP_HALT: op_known = 1'b1;
      default:                      op_known = 1'b0;
    endcase
  endfunction

  function automatic alu_op_t alu_op(input logic [OPC_W-1:0] opc);
    case (opc)
      OP_SUBU, OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      OP_SLTU, OP_SLTIU:       alu_op = ALU_SLT;
      OP_SLL:                  alu_op = ALU_SLL;
      OP_OR, OP_ORI:           alu_op = ALU_OR;
      OP_AND:                  alu_op = ALU_AND;
      default:                 alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control-unit <-> datapath bundle: opcode/flags/ready in, strobes and status out.
interface multicycle_ctrl_fsm_if
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 6,
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned CNT_W     = 32
);
  logic [OP_W-1:0]      op;
  logic                 Zero;
  logic                 InsReady;
  logic                 DataReady;
  logic                 PCWre;
  logic                 IRWre;
  logic                 ExtSel;
  logic                 WrRegDSrc;
  regdst_t              RegDst;
  logic                 RegWre;
  logic [ALUCTRL_W-1:0] ALUCtrl;
  pcsrc_t               PCSrc;
  logic                 ALUSrcA;
  logic                 ALUSrcB;
  logic                 RD;
  logic                 WR;
  logic                 ALUM2Reg;
  logic                 Halted;
  logic                 IllegalOp;
  logic [CNT_W-1:0]     RetireCnt;

  modport master (
    input  op, Zero, InsReady, DataReady,
    output PCWre, IRWre, ExtSel, WrRegDSrc, RegDst, RegWre, ALUCtrl, PCSrc,
           ALUSrcA, ALUSrcB, RD, WR, ALUM2Reg, Halted, IllegalOp, RetireCnt
  );

  modport slave (
    output op, Zero, InsReady, DataReady,
    input  PCWre, IRWre, ExtSel, WrRegDSrc, RegDst, RegWre, ALUCtrl, PCSrc,
           ALUSrcA, ALUSrcB, RD, WR, ALUM2Reg, Halted, IllegalOp, RetireCnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB sequencing with memory wait states,
// sticky HALTED, illegal-opcode pulse and a saturating retired-instruction count.
module multicycle_ctrl_fsm
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OP_W      = 6,
  parameter int unsigned ALUCTRL_W = 3,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned WAIT_EN   = 1
) (
  input  logic                CLK,
  input  logic                RST,
  multicycle_ctrl_fsm_if.master bus
);

  state_t           state;
  state_t           next;
  logic [OPC_W-1:0] opc;
  logic             op_hi;
  logic             legal;
  logic             ins_rdy;
  logic             data_rdy;
  logic             is_imm;
  logic             taken;

  logic    pc_wre;
  logic    ir_wre;
  logic    ext_sel;
  logic    wr_reg_d_src;
  regdst_t reg_dst;
  logic    reg_wre;
  pcsrc_t  pc_src;
  logic    alu_src_a;
  logic    alu_src_b;
  logic    rd;
  logic    wr;
  logic    alu_m2reg;
  logic    illegal;
  logic    retire;

  assign opc = bus.op[OPC_W-1:0];

  // Any set bit above the 6-bit opcode field makes the opcode undecodable.
  generate
    if (OP_W > OPC_W) begin : g_wide_op
      assign op_hi = |bus.op[OP_W-1:OPC_W];
    end else begin : g_narrow_op
      assign op_hi = 1'b0;
    end
  endgenerate

  assign legal    = !op_hi && op_known(opc);
  assign ins_rdy  = (WAIT_EN == 0) || bus.InsReady;
  assign data_rdy = (WAIT_EN == 0) || bus.DataReady;
  assign is_imm   = (opc == OP_ADDIU) || (opc == OP_ORI) || (opc == OP_SLTIU);
  assign taken    = (opc == OP_BNE) ? !bus.Zero : bus.Zero;

  always_ff @(posedge CLK) begin
    if (!RST) state <= ST_IF;
    else      state <= next;
  end

  // Next state and Mealy datapath strobes.
  always_comb begin
    next         = state;
    pc_wre       = 1'b0;
    ir_wre       = 1'b0;
    ext_sel      = 1'b0;
    wr_reg_d_src = 1'b0;
    reg_dst      = REGDST_RA;
    reg_wre      = 1'b0;
    pc_src       = PCSRC_SEQ;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    rd           = 1'b0;
    wr           = 1'b0;
    alu_m2reg    = 1'b0;
    illegal      = 1'b0;
    retire       = 1'b0;
    case (state)
      ST_IF: begin
        if (ins_rdy) begin
          ir_wre = 1'b1;
          pc_wre = 1'b1;
          next   = ST_ID;
        end
      end
      ST_ID: begin
        if (!legal) begin
          illegal = 1'b1;
          next    = ST_IF;
        end else begin
          case (opc)
            OP_J: begin
              pc_wre = 1'b1;
              pc_src = PCSRC_JUMP;
              retire = 1'b1;
              next   = ST_IF;
            end
            OP_JR: begin
              pc_wre = 1'b1;
              pc_src = PCSRC_RS;
              retire = 1'b1;
              next   = ST_IF;
            end
            OP_JAL: begin
              reg_wre = 1'b1;
              reg_dst = REGDST_RA;
              pc_wre  = 1'b1;
              pc_src  = PCSRC_JUMP;
              retire  = 1'b1;
              next    = ST_IF;
            end
            OP_BEQ, OP_BNE: next = ST_EXE_BR;
            OP_LW, OP_SW:   next = ST_EXE_LS;
            OP_HALT:        next = ST_HALTED;
            default:        next = ST_EXE_AL;
          endcase
        end
      end
      ST_EXE_AL: begin
        alu_src_a = (opc == OP_SLL);
        alu_src_b = is_imm;
        ext_sel   = (opc == OP_ADDIU) || (opc == OP_SLTIU);
        next      = ST_WB_AL;
      end
      ST_WB_AL: begin
        reg_wre      = 1'b1;
        wr_reg_d_src = 1'b1;
        reg_dst      = is_imm ? REGDST_RT : REGDST_RD;
        retire       = 1'b1;
        next         = ST_IF;
      end
      ST_EXE_BR: begin
        ext_sel = 1'b1;
        if (taken) begin
          pc_wre = 1'b1;
          pc_src = PCSRC_BRANCH;
        end
        retire = 1'b1;
        next   = ST_IF;
      end
      ST_EXE_LS: begin
        ext_sel   = 1'b1;
        alu_src_b = 1'b1;
        next      = ST_MEM;
      end
      ST_MEM: begin
        rd = (opc == OP_LW);
        wr = (opc != OP_LW);
        if (data_rdy) begin
          if (opc == OP_LW) begin
            next = ST_WB_LD;
          end else begin
            retire = 1'b1;
            next   = ST_IF;
          end
        end
      end
      ST_WB_LD: begin
        reg_wre      = 1'b1;
        alu_m2reg    = 1'b1;
        wr_reg_d_src = 1'b1;
        reg_dst      = REGDST_RT;
        retire       = 1'b1;
        next         = ST_IF;
      end
      ST_HALTED: next = ST_HALTED;
      default:   next = ST_IF;
    endcase
  end

  // Reset masks every write/memory strobe in the same cycle.
  assign bus.PCWre     = pc_wre & RST;
  assign bus.IRWre     = ir_wre & RST;
  assign bus.RegWre    = reg_wre & RST;
  assign bus.RD        = rd & RST;
  assign bus.WR        = wr & RST;
  assign bus.IllegalOp = illegal & RST;
  assign bus.ExtSel    = ext_sel;
  assign bus.WrRegDSrc = wr_reg_d_src;
  assign bus.RegDst    = reg_dst;
  assign bus.PCSrc     = pc_src;
  assign bus.ALUSrcA   = alu_src_a;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUM2Reg  = alu_m2reg;
  assign bus.Halted    = (state == ST_HALTED);
  assign bus.ALUCtrl   = ALUCTRL_W'(legal ? alu_op(opc) : ALU_ADD);

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (CLK),
    .clear (!RST),
    .inc   (retire),
    .count (bus.RetireCnt)
  );

endmodule
